// File: rtl/repeated_sub_divider.sv
// repeated_sub_divider
//   Unsigned divider built from repeated subtraction. The dividend and the
//   divisor arrive one after the other on a shared operand bus. The divisor
//   is subtracted from a working remainder once per clock until the remainder
//   is smaller than the divisor. The number of subtractions is the quotient.
//
// Ports
//   clk          single clock, all state changes on the rising edge
//   rst          synchronous active-high reset, takes priority over start
//   start        begins an operation, only looked at in IDLE and DONE
//   data_in      operand bus: dividend in the LDA cycle, divisor in LDB
//   quotient     registered quotient
//   remainder    registered remainder (this is the working register)
//   busy         high while in LDA, LDB or SUB
//   done         high in DONE only
//   div_by_zero  high in DONE when the captured divisor was zero
module repeated_sub_divider #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  // One-hot encoding: exactly one bit is set in any legal state. Any other
  // pattern goes to the default branch and returns to IDLE.
  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_LDA  = 5'b00010,
    S_LDB  = 5'b00100,
    S_SUB  = 5'b01000,
    S_DONE = 5'b10000
  } state_t;

  state_t         state_r;
  state_t         next_state_s;
  logic [W-1:0]   quotient_r;
  logic [W-1:0]   remainder_r;
  logic [W-1:0]   divisor_r;
  logic           dbz_flag_r;
  logic           busy_r;
  logic           done_r;
  logic           dbz_out_r;

  logic           data_zero_s;
  logic           rem_ge_div_s;
  logic           dbz_next_s;

  // Busy decode for a state. Used to register busy from the next state.
  function automatic logic state_busy(input state_t s);
    case (s)
      S_LDA, S_LDB, S_SUB: state_busy = 1'b1;
      default:             state_busy = 1'b0;
    endcase
  endfunction

  // Next-state selection plus the compare and flag terms used by the datapath.
  always_comb begin
    next_state_s = S_IDLE;
    data_zero_s  = (data_in == {W{1'b0}});
    rem_ge_div_s = (remainder_r >= divisor_r);
    // The flag that DONE will report: fresh from the bus when leaving LDB,
    // otherwise the value captured at the last LDB.
    if (state_r == S_LDB) begin
      dbz_next_s = data_zero_s;
    end else begin
      dbz_next_s = dbz_flag_r;
    end

    case (state_r)
      S_IDLE: begin
        if (start) begin
          next_state_s = S_LDA;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_LDA: begin
        next_state_s = S_LDB;
      end
      S_LDB: begin
        if (data_zero_s) begin
          next_state_s = S_DONE;
        end else begin
          next_state_s = S_SUB;
        end
      end
      S_SUB: begin
        if (rem_ge_div_s) begin
          next_state_s = S_SUB;
        end else begin
          next_state_s = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          next_state_s = S_LDA;
        end else begin
          next_state_s = S_DONE;
        end
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // State register and status outputs, registered from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      dbz_out_r <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      busy_r    <= state_busy(next_state_s);
      done_r    <= (next_state_s == S_DONE);
      dbz_out_r <= (next_state_s == S_DONE) && dbz_next_s;
    end
  end

  // Operand capture and the subtract/count step.
  always_ff @(posedge clk) begin
    if (rst) begin
      quotient_r  <= {W{1'b0}};
      remainder_r <= {W{1'b0}};
      divisor_r   <= {W{1'b0}};
      dbz_flag_r  <= 1'b0;
    end else begin
      case (state_r)
        S_LDA: begin
          remainder_r <= data_in;
        end
        S_LDB: begin
          divisor_r  <= data_in;
          quotient_r <= {W{1'b0}};
          dbz_flag_r <= data_zero_s;
        end
        S_SUB: begin
          // The divisor is nonzero here, so the quotient cannot pass
          // 2^W-1 and the subtraction cannot underflow.
          if (rem_ge_div_s) begin
            remainder_r <= remainder_r - divisor_r;
            quotient_r  <= quotient_r + {{(W-1){1'b0}}, 1'b1};
          end else begin
            remainder_r <= remainder_r;
            quotient_r  <= quotient_r;
          end
        end
        default: begin
          remainder_r <= remainder_r;
          quotient_r  <= quotient_r;
          divisor_r   <= divisor_r;
          dbz_flag_r  <= dbz_flag_r;
        end
      endcase
    end
  end

  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_out_r;

endmodule

// File: doc/repeated_sub_divider.md
REPEATED_SUB_DIVIDER -- requirements
Module: repeated_sub_divider

Interface
REQ-001 Parameter: W, default 16, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  begin operation; sampled in IDLE and DONE only.
REQ-005 data_in  input  W  shared operand bus; dividend in LDA cycle, divisor in LDB cycle.
REQ-006 quotient  output  W  registered quotient.
REQ-007 remainder  output  W  registered remainder (working register).
REQ-008 busy  output  1  high in LDA, LDB, SUB.
REQ-009 done  output  1  high in DONE only.
REQ-010 div_by_zero  output  1  high in DONE when captured divisor was 0.

Function
REQ-011 FSM states: IDLE, LDA, LDB, SUB, DONE; all outputs decoded or registered from current state, no combinational path from inputs to outputs.
REQ-012 IDLE: start=1 -> LDA; else stay.
REQ-013 LDA: on edge, remainder <= data_in (dividend); -> LDB unconditionally.
REQ-014 LDB: on edge, divisor register <= data_in, quotient <= 0; data_in==0 -> DONE with div_by_zero flag set; else -> SUB with flag cleared.
REQ-015 SUB: each edge, if remainder >= divisor then remainder <= remainder - divisor, quotient <= quotient + 1, stay; else -> DONE, registers unchanged.
REQ-016 Compare is unsigned W-bit; subtraction never underflows; quotient never wraps (max 2^W-1 when divisor=1).
REQ-017 Latency: done first high Q+4 edges after the edge sampling start (count includes that edge); divide-by-zero: 3 edges.
REQ-018 DONE: quotient, remainder, div_by_zero held stable; start=1 -> LDA (new operation, flag cleared at next LDB); else stay.
REQ-019 Divide-by-zero result: quotient = 0, remainder = dividend.
REQ-020 start ignored in LDA, LDB, SUB; data_in ignored outside LDA/LDB.
REQ-021 Exactly one state active at all times; unused encodings -> IDLE on next edge.

Reset
REQ-022 rst=1 at an edge forces IDLE regardless of state, including mid-SUB; rst dominates start.
REQ-023 Reset values: quotient=0, remainder=0, divisor register=0, busy=0, done=0, div_by_zero=0.
REQ-024 First edge with rst=0 evaluates IDLE transition rules normally.

Verification
REQ-025 start pulse, data_in=100 in LDA, 7 in LDB -> done high 18 edges after start edge; quotient=14, remainder=2, div_by_zero=0.
REQ-026 dividend 5, divisor 9 -> quotient=0, remainder=5, done after 4 edges.
REQ-027 dividend 0, divisor 0 -> DONE after 3 edges, div_by_zero=1, quotient=0, remainder=0; next start with 12/4 -> quotient=3, remainder=0, div_by_zero=0.
REQ-028 dividend 65535, divisor 1 -> quotient=65535, remainder=0, done after 65539 edges, no wrap.
REQ-029 rst asserted at 5th SUB cycle of 100/7 -> next state IDLE, all outputs zero; subsequent 9/3 -> quotient=3, remainder=0.
REQ-030 start held high throughout 20/6 -> start ignored while busy; result quotient=3, remainder=2; DONE immediately restarts to LDA on following edge.
